// File: rtl/load_ext_ctrl.sv
// ---------------------------------------------------------------------------
// load_ext_ctrl
//
// Load-data formatter for the MEM/WB path. Takes a raw big-endian memory word
// plus access size, byte offset and signedness, shifts the addressed field to
// the top of the word (stage 1), then right-justifies it with zero or sign
// extension (stage 2) and presents it with its destination tag.
//
// Handshake (both sides): a transfer happens on a rising clock edge when
// valid and ready are both 1. A producer holds valid and its payload until the
// transfer; ready never depends combinationally on the same side's valid.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous kill of both pipeline stages
//   in_valid/in_ready request handshake
//   in_data           raw memory word, byte 0 is the MSB byte
//   in_off            byte offset within the word
//   in_size           0 byte, 1 half, 2 word, 3 dword
//   in_sext           1 sign-extend, 0 zero-extend
//   in_tag            destination tag carried with the data
//   out_valid/out_ready result handshake
//   out_data, out_tag result and its tag (held stable under backpressure)
//   out_err           misaligned or illegal-size access (out_data forced to 0)
//   err_cnt           saturating count of transferred error results
//
// Build option: define LOAD_EXT_ERRCNT_EN to implement err_cnt; otherwise it
// is tied to zero.
// ---------------------------------------------------------------------------
module load_ext_ctrl #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [$clog2(DATA_W/8)-1:0]   in_off,
    input  logic [1:0]                    in_size,
    input  logic                          in_sext,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          out_err,
    output logic [15:0]                   err_cnt
);

    // Stage 1 (align) registers
    logic              s1_valid;
    logic [DATA_W-1:0] s1_aligned;
    logic [1:0]        s1_size;
    logic              s1_sext;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_err;

    // Stage 2 valid; the stage 2 payload registers are the outputs themselves
    logic              s2_valid;

    // Goes high on the first clock edge after reset release so that in_ready
    // stays low while the block is held in reset.
    logic              rst_done;

    logic              s2_adv;
    logic [DATA_W-1:0] in_aligned;
    logic              in_err;
    logic [2:0]        off_ext;
    logic [2:0]        align_mask;

    logic [6:0]        ext_shamt;
    logic [DATA_W-1:0] ext_mask;
    logic [DATA_W-1:0] ext_field;
    logic [DATA_W-1:0] ext_data;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = rst_done && (!s1_valid || s2_adv);
    assign out_valid = s2_valid;

    // Stage 1: move the addressed bytes to the top of the word and check
    // natural alignment (offset must be a multiple of the access size).
    always_comb begin
        off_ext    = 3'(in_off);
        align_mask = 3'b000;
        case (in_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        in_err     = (|(off_ext & align_mask)) || ((in_size == 2'd3) && (DATA_W == 32));
        in_aligned = in_data << {in_off, 3'b000};
    end

    // Stage 2: the field sits in the top S bits; shift it down, mask it, and
    // fill the upper bits with its MSB when sign-extending. For a full-width
    // access the mask is all ones, so ~mask is zero and the data passes through.
    always_comb begin
        ext_shamt = 7'd0;
        ext_mask  = '1;
        case (s1_size)
            2'd0: begin
                ext_shamt = 7'(DATA_W - 8);
                ext_mask  = DATA_W'(64'h0000_0000_0000_00FF);
            end
            2'd1: begin
                ext_shamt = 7'(DATA_W - 16);
                ext_mask  = DATA_W'(64'h0000_0000_0000_FFFF);
            end
            2'd2: begin
                ext_shamt = 7'(DATA_W - 32);
                ext_mask  = DATA_W'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                ext_shamt = 7'd0;
                ext_mask  = '1;
            end
        endcase
        ext_field = (s1_aligned >> ext_shamt) & ext_mask;
        ext_data  = ext_field | ((s1_sext && s1_aligned[DATA_W-1]) ? ~ext_mask : '0);
        if (s1_err) begin
            ext_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_aligned <= '0;
            s1_size    <= 2'd0;
            s1_sext    <= 1'b0;
            s1_tag     <= '0;
            s1_err     <= 1'b0;
        end else if (flush) begin
            // An input offered during flush is dropped even though in_ready is 1.
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_aligned <= in_aligned;
                s1_size    <= in_size;
                s1_sext    <= in_sext;
                s1_tag     <= in_tag;
                s1_err     <= in_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= ext_data;
                out_tag  <= s1_tag;
                out_err  <= s1_err;
            end
        end
    end

`ifdef LOAD_EXT_ERRCNT_EN
    // Counts transferred error results; flush does not clear it.
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else if (out_valid && out_ready && out_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_load_ext_ctrl.sv
// ---------------------------------------------------------------------------
// tb_load_ext_ctrl
//
// Directed and random stimulus for load_ext_ctrl. The reference model picks
// the addressed bytes out of the big-endian word one by one and extends them
// arithmetically; a queue holds expected results in order, with the cycle in
// which each request was accepted so the 2-cycle latency can be checked.
// ---------------------------------------------------------------------------
module tb_load_ext_ctrl;

    localparam int DW = 64;
    localparam int TW = 5;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_off;
    logic [1:0]    in_size;
    logic          in_sext;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic [15:0]   err_cnt;

    load_ext_ctrl #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_off    (in_off),
        .in_size   (in_size),
        .in_sext   (in_sext),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Entry format: {err, tag, data}
    logic [DW+TW:0] exp_q[$];
    int             cyc_q[$];
    int             cyc;
    logic [15:0]    exp_cnt;
    int             n_cmp;
    int             n_fail;

    localparam logic [63:0] TP_DATA = 64'h8123_4567_89AB_CDEF;

    task automatic chk(input string name, input logic [DW+TW:0] obs, input logic [DW+TW:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: gather the 2^size bytes starting at byte 'off' (byte 0 = MSB),
    // then extend arithmetically.
    function automatic logic [DW+TW:0] ref_model(input logic [63:0] d, input int off,
                                                 input int size, input bit sext,
                                                 input logic [TW-1:0] tag);
        int          n;
        logic [63:0] f;
        n = 1 << size;
        f = 64'd0;
        if ((off % n) != 0) return {1'b1, tag, 64'd0};
        for (int i = 0; i < n; i++) begin
            f = (f << 8) | {56'd0, d[63 - 8*(off + i) -: 8]};
        end
        if (sext && (n < 8) && f[8*n - 1]) begin
            f = f | ~((64'd1 << (8*n)) - 64'd1);
        end
        return {1'b0, tag, f};
    endfunction

    // One clock cycle: drive inputs just after the falling edge, check outputs
    // 1 time unit later, update the model with the transfers that the next
    // rising edge performs, then advance to the following falling edge.
    task automatic drive_cycle(input bit v, input logic [63:0] d, input int off, input int sz,
                               input bit sx, input logic [TW-1:0] tg, input bit ordy, input bit fl);
        bit exp_vis;
        bit acc;
        in_valid  = v;
        in_data   = d;
        in_off    = 3'(off);
        in_size   = 2'(sz);
        in_sext   = sx;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_vis = (exp_q.size() > 0) && ((cyc - cyc_q[0]) >= 2);
        chk("out_valid", {70'd0, out_valid}, {70'd0, exp_vis});
        chk("in_ready", {70'd0, in_ready}, {70'd0, ((exp_q.size() < 2) || ordy)});
        if (exp_vis) chk("result", {out_err, out_tag, out_data}, exp_q[0]);
        chk("err_cnt", {55'd0, err_cnt}, {55'd0, exp_cnt});
        acc = v && in_ready;
        if (exp_vis && out_valid && ordy) begin
`ifdef LOAD_EXT_ERRCNT_EN
            if (exp_q[0][DW+TW] && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
`endif
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
        end
        if (fl) begin
            exp_q.delete();
            cyc_q.delete();
        end else if (acc) begin
            exp_q.push_back(ref_model(d, off, sz, sx, tg));
            cyc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 64'd0, 0, 0, 1'b0, '0, ordy, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_cnt  = 16'd0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_off   = '0;
        in_size  = '0;
        in_sext  = 1'b0;
        in_tag   = '0;
        out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", {70'd0, out_valid}, 71'd0);
        chk("rst_out_data", {7'd0, out_data}, 71'd0);
        chk("rst_out_tag", {66'd0, out_tag}, 71'd0);
        chk("rst_out_err", {70'd0, out_err}, 71'd0);
        chk("rst_err_cnt", {55'd0, err_cnt}, 71'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", {70'd0, in_ready}, 71'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_low", {70'd0, in_ready}, 71'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready_high", {70'd0, in_ready}, 71'd1);

        // Byte, sign-extended
        drive_cycle(1'b1, TP_DATA, 0, 0, 1'b1, 5'd3, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("tp1_valid", {70'd0, out_valid}, 71'd1);
        chk("tp1_data", {7'd0, out_data}, {7'd0, 64'hFFFF_FFFF_FFFF_FF81});
        chk("tp1_tag", {66'd0, out_tag}, 71'd3);
        chk("tp1_err", {70'd0, out_err}, 71'd0);
        idle(1, 1'b1);

        // Half, zero-extended
        drive_cycle(1'b1, TP_DATA, 2, 1, 1'b0, 5'd7, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("tp2_data", {7'd0, out_data}, {7'd0, 64'h0000_0000_0000_4567});
        idle(1, 1'b1);

        // Word, sign-extended
        drive_cycle(1'b1, TP_DATA, 4, 2, 1'b1, 5'd9, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("tp3_data", {7'd0, out_data}, {7'd0, 64'hFFFF_FFFF_89AB_CDEF});
        idle(1, 1'b1);

        // Misaligned word
        drive_cycle(1'b1, TP_DATA, 3, 2, 1'b1, 5'd11, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("tp4_err", {70'd0, out_err}, 71'd1);
        chk("tp4_data", {7'd0, out_data}, 71'd0);
        idle(1, 1'b1);
`ifdef LOAD_EXT_ERRCNT_EN
        chk("tp4_err_cnt", {55'd0, err_cnt}, 71'd1);
`else
        chk("tp4_err_cnt", {55'd0, err_cnt}, 71'd0);
`endif

        // Backpressure: three back-to-back requests with out_ready low
        drive_cycle(1'b1, 64'h0123_4567_89AB_CDEF, 1, 0, 1'b0, 5'd1, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hFEDC_BA98_7654_3210, 6, 1, 1'b1, 5'd2, 1'b0, 1'b0);
        #1;
        chk("bp_third_in_ready", {70'd0, in_ready}, 71'd0);
        drive_cycle(1'b1, 64'h0F0F_F0F0_AAAA_5555, 0, 3, 1'b1, 5'd4, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        chk("bp_drained", {39'd0, 32'(exp_q.size())}, 71'd0);

        // Random stream with random backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            logic [63:0] rd;
            int          rsz;
            int          roff;
            rd   = {$urandom(), $urandom()};
            rsz  = int'($urandom_range(0, 3));
            roff = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                               : (int'($urandom_range(0, 7)) & ~((1 << rsz) - 1));
            drive_cycle(1'($urandom_range(0, 3) != 0), rd, roff, rsz, 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) < 7),
                        1'($urandom_range(0, 39) == 0));
        end
        idle(4, 1'b1);

        // Flush with two entries in flight and a new request offered
        drive_cycle(1'b1, 64'h1111_2222_3333_4444, 0, 2, 1'b0, 5'd5, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h5555_6666_7777_8888, 0, 3, 1'b0, 5'd6, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h9999_AAAA_BBBB_CCCC, 0, 1, 1'b0, 5'd7, 1'b0, 1'b1);
        chk("flush_out_valid", {70'd0, out_valid}, 71'd0);
        idle(4, 1'b1);

        // Asynchronous reset mid-stream
        drive_cycle(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 1'b1, 5'd12, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hCAFE_BABE_1234_5678, 2, 1, 1'b1, 5'd13, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {70'd0, out_valid}, 71'd0);
        chk("arst_out_data", {7'd0, out_data}, 71'd0);
        chk("arst_out_tag", {66'd0, out_tag}, 71'd0);
        chk("arst_out_err", {70'd0, out_err}, 71'd0);
        chk("arst_err_cnt", {55'd0, err_cnt}, 71'd0);
        exp_q.delete();
        cyc_q.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_cycle(1'b1, TP_DATA, 6, 1, 1'b1, 5'd20, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("post_rst_data", {7'd0, out_data}, {7'd0, 64'h0000_0000_0000_CDEF} | {7'd0, 64'hFFFF_FFFF_FFFF_0000});
        idle(3, 1'b1);
        chk("final_empty", {39'd0, 32'(exp_q.size())}, 71'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
